issue_hazard_controller: RTL and testbench
==========================================

// Module: issue_hazard_controller
// PURPOSE
//  Sits between instruction fetch and dependency_check_module in the 8-bit MIPS pipeline.
//  Accepts 20-bit instructions over a valid/ready handshake and issues one per cycle.
//  Inserts NOP bubbles on load-use hazards, because forwarding cannot cover a load result before MEM completes.
//  Sequences HALT: drains the pipeline, then freezes issue.
// PARAMETERS
//  LOAD_LAT    1   cycles a load result is unforwardable after issue (1..7)
//  PIPE_DEPTH  4   cycles from issue to writeback, used by HALT drain (1..15)
// PORTS
//  clk          in   1   system clock, rising edge
//  reset        in   1   asynchronous, active-high reset
//  fetch_ins    in   20  instruction {op[19:15], RW[14:10], RA[9:5], RB[4:0]}; Imm = [7:0]
//  fetch_valid  in   1   fetch_ins valid this cycle
//  fetch_ready  out  1   controller consumes fetch_ins this cycle (combinational)
//  iss_ins      out  20  registered instruction to dependency_check_module (ins)
//  iss_valid    out  1   iss_ins is a real instruction or inserted bubble
//  bubble       out  1   iss_ins is a hazard-inserted NOP
//  pc_hold      out  1   fetch must hold PC (= fetch_valid & ~fetch_ready)
//  halted       out  1   HALT drained; no further issue until reset
//  stall_cnt    out  16  saturating count of hazard bubbles
// BEHAVIOUR
//  Reset: iss_ins=OP_NOP word {11111,15'b0}, iss_valid=0, bubble=0, halted=0, stall_cnt=0,
//   ld_cnt=0, ld_rd=0, state=RUN. Reset mid-stall/mid-drain aborts it immediately.
//  Decode classes: LOAD op=10100 (writes RW, reads RA); STORE op=10101 (reads RA,RB);
//   IMM op[4:3]=01 (writes RW, reads RA); HALT op=11110; NOP op=11111 (reads nothing);
//   every other op writes RW and reads RA, RB. R0 is never a hazard source or target.
//  Load shadow: on issuing LOAD, ld_rd<=RW, ld_cnt<=LOAD_LAT; else ld_cnt decrements,
//   saturating at 0 (also on bubble/idle cycles).
//  hazard = fetch_valid & state==RUN & ld_cnt!=0 & ld_rd!=0 & (a read source == ld_rd).
//  fetch_ready = state==RUN & ~hazard. pc_hold = fetch_valid & ~fetch_ready.
//  FSM:
//   RUN: fetch_valid & ~hazard: iss_ins<=fetch_ins, iss_valid<=1, bubble<=0 (1-cycle latency).
//    hazard: iss_ins<=NOP, iss_valid<=1, bubble<=1, stall_cnt++ (hold at 16'hFFFF).
//    ~fetch_valid: iss_ins<=NOP, iss_valid<=0, bubble<=0.
//    Issuing HALT: go to DRAIN, drain_cnt<=PIPE_DEPTH.
//   DRAIN: fetch_ready=0; issue NOP with iss_valid=0; drain_cnt--; at 0 go to HALTED.
//   HALTED: halted=1 (registered), fetch_ready=0, iss_valid=0. Only reset leaves it.
//  Back-to-back loads: the newer load overwrites the shadow (ld_rd, ld_cnt=LOAD_LAT).
//  A load hazarding on a prior load stalls like any consumer.
//  Load with RW=R0 never arms a hazard.
//  LOAD_LAT=N: a dependent instruction immediately after a load gets exactly N bubbles.
// STRUCTURE
//  Shared package mips_isa_pkg: OP_LOAD, OP_STORE, OP_HALT, OP_NOP, IMM class mask,
//   field bit ranges, NOP instruction word, FSM state enum {RUN, DRAIN, HALTED}.
//  One sub-module: ins_class_decode (combinational: reads_ra, reads_rb, writes_rw,
//   is_load, is_halt from the opcode). Shadow registers, FSM and counters stay in the top.
// TESTING
//  1 Reset held 3 cycles, fetch_valid=1 -> all outputs at reset values; fetch_ready=1 on release.
//  2 ADD R1,R2,R3 then ADD R4,R1,R5 (00000_00001_00010_00011, 00000_00100_00001_00101)
//    -> 2 consecutive issues, bubble=0, stall_cnt=0.
//  3 LOAD R4,[R1] (10100_00100_00001_00000), then 00100_00101_00001_00100 reading R4,
//    LOAD_LAT=1 -> 1 bubble, pc_hold=1 for 1 cycle, stall_cnt=1. LOAD_LAT=3 -> 3 bubbles.
//  4 LOAD R0 then consumer of R0; LOAD R4 then IMM op reading only RA=R1
//    -> no bubble in either case.
//  5 HALT, PIPE_DEPTH=4 -> fetch_ready=0 at once; halted=1 after 4 drain cycles;
//    later fetch_valid is ignored.
//  6 Reset asserted mid-stall (LOAD_LAT=3, 2nd bubble) -> outputs at reset values
//    asynchronously; the pending consumer reissues with no bubble.

Source files
------------

// File: rtl/mips_isa_pkg.sv
// Shared ISA definitions for the 8-bit MIPS pipeline: opcodes, field ranges,
// the canonical NOP word and the issue controller state encoding.
package mips_isa_pkg;

  localparam int INS_W = 20;

  localparam int OP_HI = 19;
  localparam int OP_LO = 15;
  localparam int RW_HI = 14;
  localparam int RW_LO = 10;
  localparam int RA_HI = 9;
  localparam int RA_LO = 5;
  localparam int RB_HI = 4;
  localparam int RB_LO = 0;

  localparam logic [4:0] OP_LOAD  = 5'b10100;
  localparam logic [4:0] OP_STORE = 5'b10101;
  localparam logic [4:0] OP_HALT  = 5'b11110;
  localparam logic [4:0] OP_NOP   = 5'b11111;

  // Immediate class is any opcode with op[4:3] == 2'b01
  localparam logic [4:0] IMM_MASK  = 5'b11000;
  localparam logic [4:0] IMM_MATCH = 5'b01000;

  localparam logic [INS_W-1:0] NOP_WORD = {OP_NOP, 15'b0};

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

endpackage

// File: rtl/ins_class_decode.sv
// Opcode classifier: which register fields an instruction reads/writes and
// whether it is a load or a halt.
module ins_class_decode
  import mips_isa_pkg::*;
(
  input  logic [4:0] op,
  output logic       reads_ra,
  output logic       reads_rb,
  output logic       writes_rw,
  output logic       is_load,
  output logic       is_halt
);

  always_comb begin
    reads_ra  = 1'b1;
    reads_rb  = 1'b1;
    writes_rw = 1'b1;
    is_load   = 1'b0;
    is_halt   = 1'b0;
    if (op == OP_LOAD) begin
      reads_rb = 1'b0;
      is_load  = 1'b1;
    end else if (op == OP_STORE) begin
      writes_rw = 1'b0;
    end else if ((op & IMM_MASK) == IMM_MATCH) begin
      reads_rb = 1'b0;
    end else if (op == OP_HALT) begin
      reads_ra  = 1'b0;
      reads_rb  = 1'b0;
      writes_rw = 1'b0;
      is_halt   = 1'b1;
    end else if (op == OP_NOP) begin
      reads_ra  = 1'b0;
      reads_rb  = 1'b0;
      writes_rw = 1'b0;
    end
  end

endmodule

// File: rtl/issue_hazard_controller.sv
// Issue stage between fetch and dependency check: one instruction per cycle,
// NOP bubbles on load-use hazards, and HALT drain/freeze sequencing.
module issue_hazard_controller
  import mips_isa_pkg::*;
#(
  parameter int LOAD_LAT   = 1,
  parameter int PIPE_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [INS_W-1:0]  fetch_ins,
  input  logic              fetch_valid,
  output logic              fetch_ready,
  output logic [INS_W-1:0]  iss_ins,
  output logic              iss_valid,
  output logic              bubble,
  output logic              pc_hold,
  output logic              halted,
  output logic [15:0]       stall_cnt
);

  state_t      state_reg, state_next;
  logic [3:0]  drain_reg, drain_next;
  logic [2:0]  ld_cnt_reg, ld_cnt_next;
  logic [4:0]  ld_rd_reg, ld_rd_next;

  logic [INS_W-1:0] ins_next;
  logic             valid_next;
  logic             bubble_next;
  logic [15:0]      stall_next;

  logic [4:0] op, rw, ra, rb;
  logic       reads_ra, reads_rb, writes_rw, is_load, is_halt;
  logic       hazard, accept, src_match;

  assign op = fetch_ins[OP_HI:OP_LO];
  assign rw = fetch_ins[RW_HI:RW_LO];
  assign ra = fetch_ins[RA_HI:RA_LO];
  assign rb = fetch_ins[RB_HI:RB_LO];

  ins_class_decode u_decode (
    .op        (op),
    .reads_ra  (reads_ra),
    .reads_rb  (reads_rb),
    .writes_rw (writes_rw),
    .is_load   (is_load),
    .is_halt   (is_halt)
  );

  // R0 is hardwired, so it can never be the source side of a hazard
  assign src_match = (reads_ra && ra != 5'd0 && ra == ld_rd_reg) ||
                     (reads_rb && rb != 5'd0 && rb == ld_rd_reg);

  assign hazard      = fetch_valid && state_reg == RUN && ld_cnt_reg != 3'd0 &&
                       ld_rd_reg != 5'd0 && src_match;
  assign fetch_ready = (state_reg == RUN) && !hazard;
  assign pc_hold     = fetch_valid && !fetch_ready;
  assign accept      = fetch_valid && fetch_ready;

  always_comb begin
    state_next = state_reg;
    drain_next = drain_reg;
    case (state_reg)
      RUN: begin
        if (accept && is_halt) begin
          state_next = DRAIN;
          drain_next = PIPE_DEPTH[3:0];
        end
      end
      DRAIN: begin
        if (drain_reg != 4'd0) drain_next = drain_reg - 4'd1;
        if (drain_reg <= 4'd1) state_next = HALTED;
      end
      HALTED:  state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    ins_next    = NOP_WORD;
    valid_next  = 1'b0;
    bubble_next = 1'b0;
    stall_next  = stall_cnt;
    ld_rd_next  = ld_rd_reg;
    ld_cnt_next = (ld_cnt_reg != 3'd0) ? ld_cnt_reg - 3'd1 : 3'd0;
    if (accept) begin
      ins_next   = fetch_ins;
      valid_next = 1'b1;
      if (is_load) begin
        // A load to R0 leaves ld_rd at 0, which never arms a hazard
        ld_rd_next  = writes_rw ? rw : 5'd0;
        ld_cnt_next = LOAD_LAT[2:0];
      end
    end else if (hazard) begin
      valid_next  = 1'b1;
      bubble_next = 1'b1;
      if (stall_cnt != 16'hFFFF) stall_next = stall_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= RUN;
      drain_reg  <= 4'd0;
      ld_cnt_reg <= 3'd0;
      ld_rd_reg  <= 5'd0;
      iss_ins    <= NOP_WORD;
      iss_valid  <= 1'b0;
      bubble     <= 1'b0;
      halted     <= 1'b0;
      stall_cnt  <= 16'd0;
    end else begin
      state_reg  <= state_next;
      drain_reg  <= drain_next;
      ld_cnt_reg <= ld_cnt_next;
      ld_rd_reg  <= ld_rd_next;
      iss_ins    <= ins_next;
      iss_valid  <= valid_next;
      bubble     <= bubble_next;
      halted     <= (state_next == HALTED);
      stall_cnt  <= stall_next;
    end
  end

endmodule

// File: tb/tb_issue_hazard_controller.sv
// Directed bench: dut_a (LOAD_LAT=1) and dut_b (LOAD_LAT=3) with a scoreboard
// of expected issue-port values checked one cycle after each drive.
module tb_issue_hazard_controller;

  localparam logic [19:0] NOP   = {5'b11111, 15'b0};
  localparam logic [19:0] ADD1  = 20'b00000_00001_00010_00011;
  localparam logic [19:0] ADD2  = 20'b00000_00100_00001_00101;
  localparam logic [19:0] LDR4  = 20'b10100_00100_00001_00000;
  localparam logic [19:0] USER4 = 20'b00100_00101_00001_00100;
  localparam logic [19:0] LDR0  = 20'b10100_00000_00001_00000;
  localparam logic [19:0] USER0 = 20'b00000_00110_00000_00000;
  localparam logic [19:0] IMMR1 = 20'b01000_00101_00001_00100;
  localparam logic [19:0] LDR5  = 20'b10100_00101_00100_00000;
  localparam logic [19:0] USER5 = 20'b00000_00111_00101_00010;
  localparam logic [19:0] HALTI = 20'b11110_00000_00000_00000;

  typedef struct {
    bit          sel;
    logic [19:0] ins;
    logic        valid;
    logic        bub;
    string       tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] fetch_ins = '0;
  logic        fv_a = 1'b0, fv_b = 1'b0;
  logic        rdy_a, rdy_b, hold_a, hold_b, val_a, val_b, bub_a, bub_b, hlt_a, hlt_b;
  logic [19:0] ins_a, ins_b;
  logic [15:0] st_a, st_b;

  int checks = 0;
  int failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  issue_hazard_controller #(.LOAD_LAT(1), .PIPE_DEPTH(4)) dut_a (
    .clk(clk), .reset(reset), .fetch_ins(fetch_ins), .fetch_valid(fv_a),
    .fetch_ready(rdy_a), .iss_ins(ins_a), .iss_valid(val_a), .bubble(bub_a),
    .pc_hold(hold_a), .halted(hlt_a), .stall_cnt(st_a));

  issue_hazard_controller #(.LOAD_LAT(3), .PIPE_DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .fetch_ins(fetch_ins), .fetch_valid(fv_b),
    .fetch_ready(rdy_b), .iss_ins(ins_b), .iss_valid(val_b), .bubble(bub_b),
    .pc_hold(hold_b), .halted(hlt_b), .stall_cnt(st_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: compares the registered issue port after each edge
  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, ".ins"},    e.sel ? ins_b : ins_a, e.ins);
      chk({e.tag, ".valid"},  e.sel ? val_b : val_a, e.valid);
      chk({e.tag, ".bubble"}, e.sel ? bub_b : bub_a, e.bub);
      $display("txn %s dut=%0d ins=%05h valid=%0b bubble=%0b", e.tag, e.sel,
               e.sel ? ins_b : ins_a, e.sel ? val_b : val_a, e.sel ? bub_b : bub_a);
    end
  end

  // Drive one cycle (called at posedge+2); checks handshake mid-cycle
  task automatic cycle(input bit sel, input logic [19:0] ins, input bit v, input bit exp_rdy,
                       input logic [19:0] exp_ins, input bit exp_v, input bit exp_b,
                       input string tag);
    exp_t e;
    fetch_ins = ins;
    fv_a = (sel == 1'b0) ? v : 1'b0;
    fv_b = (sel == 1'b1) ? v : 1'b0;
    @(negedge clk);
    chk({tag, ".ready"}, sel ? rdy_b : rdy_a, exp_rdy);
    chk({tag, ".pc_hold"}, sel ? hold_b : hold_a, v & ~exp_rdy);
    e.sel = sel; e.ins = exp_ins; e.valid = exp_v; e.bub = exp_b; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input bit sel, input logic [19:0] ins, input int nb, input string tag);
    for (int i = 0; i <= nb; i++) begin
      if (i < nb) cycle(sel, ins, 1'b1, 1'b0, NOP, 1'b1, 1'b1, {tag, "_bub"});
      else        cycle(sel, ins, 1'b1, 1'b1, ins, 1'b1, 1'b0, tag);
    end
  endtask

  task automatic idle(input bit sel, input string tag);
    cycle(sel, NOP, 1'b0, 1'b1, NOP, 1'b0, 1'b0, tag);
  endtask

  initial begin
    // 1: reset held 3 cycles with fetch_valid high
    fetch_ins = ADD1; fv_a = 1'b1; fv_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst.ins_a", ins_a, NOP);
      chk("rst.valid_a", val_a, 1'b0);
      chk("rst.bubble_a", bub_a, 1'b0);
      chk("rst.halted_a", hlt_a, 1'b0);
      chk("rst.stall_a", st_a, 16'd0);
      chk("rst.valid_b", val_b, 1'b0);
      $display("txn reset cycle %0d", i);
    end
    fv_a = 1'b0; fv_b = 1'b0;
    reset = 1'b0;
    #1 chk("rst.release_ready_a", rdy_a, 1'b1);
    @(posedge clk); #2;

    // 2: independent ALU ops issue back to back
    issue(0, ADD1, 0, "add1");
    issue(0, ADD2, 0, "add2");
    idle(0, "idle_a");
    chk("add.stall_a", st_a, 16'd0);

    // 3: load-use with LOAD_LAT=1
    issue(0, LDR4, 0, "ld_r4");
    issue(0, USER4, 1, "use_r4");
    chk("ld1.stall_a", st_a, 16'd1);

    // 4: R0 load and RA-only immediate never stall; chained loads do
    issue(0, LDR0, 0, "ld_r0");
    issue(0, USER0, 0, "use_r0");
    issue(0, LDR4, 0, "ld_r4b");
    issue(0, IMMR1, 0, "imm_r1");
    chk("nohaz.stall_a", st_a, 16'd1);
    issue(0, LDR4, 0, "ld_r4c");
    issue(0, LDR5, 1, "ld_r5_on_r4");
    issue(0, USER5, 1, "use_r5");
    idle(0, "idle_a2");
    chk("chain.stall_a", st_a, 16'd3);

    // 3b: LOAD_LAT=3 gives three bubbles
    issue(1, LDR4, 0, "b_ld_r4");
    issue(1, USER4, 3, "b_use_r4");
    idle(1, "idle_b");
    chk("ld3.stall_b", st_b, 16'd3);

    // 6: async reset during the second bubble
    issue(1, LDR4, 0, "b_ld_r4_rst");
    cycle(1, USER4, 1'b1, 1'b0, NOP, 1'b1, 1'b1, "b_bub1");
    cycle(1, USER4, 1'b1, 1'b0, NOP, 1'b1, 1'b1, "b_bub2");
    reset = 1'b1;
    #1;
    chk("arst.valid_b", val_b, 1'b0);
    chk("arst.bubble_b", bub_b, 1'b0);
    chk("arst.ins_b", ins_b, NOP);
    chk("arst.stall_b", st_b, 16'd0);
    chk("arst.ready_b", rdy_b, 1'b1);
    $display("txn async reset mid-stall");
    @(posedge clk);
    fv_b = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #2;
    issue(1, USER4, 0, "b_reissue");
    idle(1, "idle_b2");
    chk("arst.stall_after_b", st_b, 16'd0);

    // 5: HALT drains PIPE_DEPTH cycles then freezes
    issue(0, HALTI, 0, "halt");
    for (int k = 1; k <= 6; k++) begin
      cycle(0, ADD1, 1'b1, 1'b0, NOP, 1'b0, 1'b0, $sformatf("drain%0d", k));
      chk($sformatf("drain%0d.halted", k), hlt_a, (k >= 4) ? 1'b1 : 1'b0);
    end
    fv_a = 1'b0;
    @(posedge clk); #2;
    chk("sb.empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
